// File: rtl/decoder_driver_pkg.sv
// Shared definitions for decoder_driver: op codes, FSM states and the packed
// command word {op, flags, check, branch} carried through the command FIFO.
package decoder_driver_pkg;

  localparam int unsigned OP_W     = 2;
  localparam int unsigned FLAGS_W  = 4;
  localparam int unsigned BRANCH_W = 16;

  localparam logic [OP_W-1:0] OP_SET_FLAGS   = 2'd0;
  localparam logic [OP_W-1:0] OP_LOAD_BRANCH = 2'd1;
  localparam logic [OP_W-1:0] OP_STEP        = 2'd2;
  localparam logic [OP_W-1:0] OP_RSVD        = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0]     op;
    logic [FLAGS_W-1:0]  flags;
    logic [FLAGS_W-1:0]  check;
    logic [BRANCH_W-1:0] branch;
  } cmd_t;

  localparam int unsigned CMD_W = $bits(cmd_t);

  function automatic cmd_t pack_cmd(
    input logic [OP_W-1:0]     op,
    input logic [FLAGS_W-1:0]  flags,
    input logic [FLAGS_W-1:0]  check,
    input logic [BRANCH_W-1:0] branch
  );
    cmd_t c;
    c.op     = op;
    c.flags  = flags;
    c.check  = check;
    c.branch = branch;
    return c;
  endfunction

endpackage

// File: rtl/decoder_driver_cmd_fifo.sv
// cmd_fifo: power-of-two deep synchronous FIFO with registered count.
// A push while full is honoured only when a pop happens in the same cycle.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0);
    do_push  = push && ((count_q != FULL_CNT) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W + 1)'(1);
      2'b01:   count_d = count_q - (PTR_W + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/decoder_driver.sv
// decoder_driver: queues commands and drives the decoder rx_* strobe protocol,
// capturing the PC on the ready handshake. Watchdog: DECODER_DRIVER_TIMEOUT_EN.
module decoder_driver
  import decoder_driver_pkg::*;
#(
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                enable,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [OP_W-1:0]     s_op,
  input  logic [FLAGS_W-1:0]  s_flags,
  input  logic [FLAGS_W-1:0]  s_check,
  input  logic [BRANCH_W-1:0] s_branch,
  output logic                tx_enable,
  output logic                tx_write_flags,
  output logic                tx_write_branch,
  output logic                tx_strobe,
  output logic [FLAGS_W-1:0]  tx_input_flags,
  output logic [FLAGS_W-1:0]  tx_check_flags,
  output logic [BRANCH_W-1:0] tx_branch,
  input  logic [BRANCH_W-1:0] rx_program_counter,
  input  logic                rx_ready,
  output logic [BRANCH_W-1:0] pc_out,
  output logic                pc_valid,
  output logic                busy,
  output logic                err_badop,
  output logic                err_timeout
);

  state_e                state_q, state_d;
  logic                  wf_q, wf_d, wb_q, wb_d, st_q, st_d;
  logic [FLAGS_W-1:0]    flags_q, flags_d, check_q, check_d;
  logic [BRANCH_W-1:0]   branch_q, branch_d, pc_q, pc_d;
  logic                  pcv_q, pcv_d, bad_q, bad_d;

  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0]      fifo_dout;
  logic [$clog2(DEPTH):0] fifo_count;
  cmd_t                  head;

  assign fifo_push = s_valid && s_ready;
  assign head      = cmd_t'(fifo_dout);

  cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (aclk),
    .rst   (areset),
    .push  (fifo_push),
    .din   (pack_cmd(s_op, s_flags, s_check, s_branch)),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

`ifdef DECODER_DRIVER_TIMEOUT_EN
  localparam int unsigned TO_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            to_q, to_d;
`else
  // The limit only matters to the watchdog build.
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = |TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    wf_d     = 1'b0;
    wb_d     = 1'b0;
    st_d     = 1'b0;
    pcv_d    = 1'b0;
    bad_d    = 1'b0;
    flags_d  = flags_q;
    check_d  = check_q;
    branch_d = branch_q;
    pc_d     = pc_q;
`ifdef DECODER_DRIVER_TIMEOUT_EN
    cnt_d    = cnt_q;
    to_d     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (enable && !fifo_empty) begin
          fifo_pop = 1'b1;
          // Pulse registers are set on the pop edge so they are high during ISSUE.
          case (head.op)
            OP_SET_FLAGS: begin
              flags_d = head.flags;
              check_d = head.check;
              wf_d    = 1'b1;
              state_d = ST_ISSUE;
            end
            OP_LOAD_BRANCH: begin
              branch_d = head.branch;
              wb_d     = 1'b1;
              state_d  = ST_ISSUE;
            end
            OP_STEP: begin
              st_d    = 1'b1;
              state_d = ST_ISSUE;
            end
            default: bad_d = 1'b1;
          endcase
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
`ifdef DECODER_DRIVER_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      ST_WAIT: begin
        if (rx_ready) begin
          pc_d    = rx_program_counter;
          pcv_d   = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef DECODER_DRIVER_TIMEOUT_EN
        else if (cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          to_d    = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TO_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q  <= ST_IDLE;
      wf_q     <= 1'b0;
      wb_q     <= 1'b0;
      st_q     <= 1'b0;
      flags_q  <= '0;
      check_q  <= '0;
      branch_q <= '0;
      pc_q     <= '0;
      pcv_q    <= 1'b0;
      bad_q    <= 1'b0;
`ifdef DECODER_DRIVER_TIMEOUT_EN
      cnt_q    <= '0;
      to_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      wf_q     <= wf_d;
      wb_q     <= wb_d;
      st_q     <= st_d;
      flags_q  <= flags_d;
      check_q  <= check_d;
      branch_q <= branch_d;
      pc_q     <= pc_d;
      pcv_q    <= pcv_d;
      bad_q    <= bad_d;
`ifdef DECODER_DRIVER_TIMEOUT_EN
      cnt_q    <= cnt_d;
      to_q     <= to_d;
`endif
    end
  end

  assign s_ready         = !fifo_full;
  assign tx_enable       = enable;
  assign tx_write_flags  = wf_q;
  assign tx_write_branch = wb_q;
  assign tx_strobe       = st_q;
  assign tx_input_flags  = flags_q;
  assign tx_check_flags  = check_q;
  assign tx_branch       = branch_q;
  assign pc_out          = pc_q;
  assign pc_valid        = pcv_q;
  assign err_badop       = bad_q;
  assign busy            = (state_q != ST_IDLE) || (fifo_count != '0);
`ifdef DECODER_DRIVER_TIMEOUT_EN
  assign err_timeout     = to_q;
`else
  assign err_timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_decoder_driver.sv
// Directed self-checking bench for decoder_driver; a monitor counts the
// decoder pulses and logs branch payloads, each test checks its own deltas.
module tb_decoder_driver;

  localparam logic [1:0] C_SET = 2'd0;
  localparam logic [1:0] C_BR  = 2'd1;
  localparam logic [1:0] C_ST  = 2'd2;
  localparam logic [1:0] C_BAD = 2'd3;

  logic        aclk = 1'b0;
  logic        areset, enable, s_valid, s_ready;
  logic [1:0]  s_op;
  logic [3:0]  s_flags, s_check;
  logic [15:0] s_branch;
  logic        tx_enable, tx_write_flags, tx_write_branch, tx_strobe;
  logic [3:0]  tx_input_flags, tx_check_flags;
  logic [15:0] tx_branch, rx_program_counter, pc_out;
  logic        rx_ready, pc_valid, busy, err_badop, err_timeout;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  int unsigned n_wf = 0, n_wb = 0, n_st = 0, n_pcv = 0, n_bad = 0, n_to = 0;
  int unsigned wb_cyc = 0, st_cyc = 0, to_cyc = 0;
  logic [15:0] br_log[$];

  decoder_driver #(
    .DEPTH          (4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .aclk               (aclk),
    .areset             (areset),
    .enable             (enable),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_op               (s_op),
    .s_flags            (s_flags),
    .s_check            (s_check),
    .s_branch           (s_branch),
    .tx_enable          (tx_enable),
    .tx_write_flags     (tx_write_flags),
    .tx_write_branch    (tx_write_branch),
    .tx_strobe          (tx_strobe),
    .tx_input_flags     (tx_input_flags),
    .tx_check_flags     (tx_check_flags),
    .tx_branch          (tx_branch),
    .rx_program_counter (rx_program_counter),
    .rx_ready           (rx_ready),
    .pc_out             (pc_out),
    .pc_valid           (pc_valid),
    .busy               (busy),
    .err_badop          (err_badop),
    .err_timeout        (err_timeout)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc <= cyc + 1;

  always begin
    @(posedge aclk);
    #2;
    if (tx_write_flags) n_wf++;
    if (tx_write_branch) begin
      n_wb++;
      wb_cyc = cyc;
      br_log.push_back(tx_branch);
    end
    if (tx_strobe) begin
      n_st++;
      st_cyc = cyc;
    end
    if (pc_valid) n_pcv++;
    if (err_badop) n_bad++;
    if (err_timeout) begin
      n_to++;
      to_cyc = cyc;
    end
  end

  // Called at a negedge; the command is accepted on the following posedge.
  task automatic push(input logic [1:0] op, input logic [3:0] f, input logic [3:0] c,
                      input logic [15:0] b);
    s_valid  = 1'b1;
    s_op     = op;
    s_flags  = f;
    s_check  = c;
    s_branch = b;
    @(negedge aclk);
    s_valid  = 1'b0;
  endtask

  task automatic wait_idle(input int unsigned max_cycles, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < max_cycles; i++) begin
      @(negedge aclk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    areset = 1'b1; enable = 1'b0; s_valid = 1'b0; s_op = '0; s_flags = '0; s_check = '0;
    s_branch = '0; rx_ready = 1'b0; rx_program_counter = '0;
    repeat (2) @(negedge aclk);
    vectors++;
    if ({tx_write_flags, tx_write_branch, tx_strobe, tx_input_flags, tx_check_flags, tx_branch,
         pc_out, pc_valid, busy, err_badop, err_timeout, tx_enable} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: outputs not all zero (busy=%b pc_out=%h tx_branch=%h)",
               busy, pc_out, tx_branch);
    end
    vectors++;
    if (s_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_s_ready: got %b want 1", s_ready);
    end
    areset = 1'b0;
    enable = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_set_flags;
    int unsigned wf0 = n_wf, pcv0 = n_pcv;
    push(C_SET, 4'hA, 4'h3, 16'h0000);
    @(negedge aclk);
    vectors++;
    if ({tx_write_flags, tx_strobe, tx_write_branch, tx_input_flags, tx_check_flags} !== {3'b100, 4'hA, 4'h3}) begin
      miscompares++;
      $display("FAIL set_flags_issue: wf/st/wb/flags/check=%b%b%b/%h/%h want 100/a/3",
               tx_write_flags, tx_strobe, tx_write_branch, tx_input_flags, tx_check_flags);
    end
    @(negedge aclk);
    vectors++;
    if ({tx_write_flags, pc_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL set_flags_wait: wf=%b pc_valid=%b want 0 0", tx_write_flags, pc_valid);
    end
    rx_program_counter = 16'h0055;
    rx_ready = 1'b1;
    @(negedge aclk);
    rx_ready = 1'b0;
    vectors++;
    if ({pc_valid, pc_out} !== {1'b1, 16'h0055}) begin
      miscompares++;
      $display("FAIL set_flags_pc: pc_valid=%b pc_out=%h want 1 0055", pc_valid, pc_out);
    end
    @(negedge aclk);
    vectors++;
    if ({pc_valid, busy, n_wf - wf0, n_pcv - pcv0} !== {2'b00, 32'd1, 32'd1}) begin
      miscompares++;
      $display("FAIL set_flags_done: pc_valid=%b busy=%b wf_pulses=%0d pcv_pulses=%0d want 0 0 1 1",
               pc_valid, busy, n_wf - wf0, n_pcv - pcv0);
    end
  endtask

  task automatic test_branch_step;
    int unsigned wb0 = n_wb, st0 = n_st, pcv0 = n_pcv;
    bit ok;
    rx_program_counter = 16'h1234;
    rx_ready = 1'b1;
    push(C_BR, 4'h0, 4'h0, 16'h1234);
    push(C_ST, 4'h0, 4'h0, 16'h0000);
    wait_idle(30, ok);
    rx_ready = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL branch_step_timeout: busy=%b after 30 cycles want 0", busy);
    end
    vectors++;
    if ({n_wb - wb0, n_st - st0, n_pcv - pcv0} !== {32'd1, 32'd1, 32'd2}) begin
      miscompares++;
      $display("FAIL branch_step_pulses: wb=%0d st=%0d pcv=%0d want 1 1 2",
               n_wb - wb0, n_st - st0, n_pcv - pcv0);
    end
    vectors++;
    if ({br_log[br_log.size() - 1], tx_branch, pc_out} !== {16'h1234, 16'h1234, 16'h1234}) begin
      miscompares++;
      $display("FAIL branch_step_values: logged=%h tx_branch=%h pc_out=%h want 1234 x3",
               br_log[br_log.size() - 1], tx_branch, pc_out);
    end
    vectors++;
    if (st_cyc - wb_cyc !== 32'd3) begin
      miscompares++;
      $display("FAIL branch_step_spacing: %0d cycles between pulses want 3", st_cyc - wb_cyc);
    end
  endtask

  task automatic test_back_to_back;
    int unsigned wb0 = n_wb, pcv0 = n_pcv;
    bit ok;
    logic [15:0] want;
    br_log.delete();
    rx_program_counter = 16'hABCD;
    rx_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      vectors++;
      if (s_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready_%0d: s_ready=%b want 1", i, s_ready);
      end
      push(C_BR, 4'h0, 4'h0, 16'h1001 + 16'(i));
    end
    repeat (2) @(negedge aclk);
    vectors++;
    if ({s_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_full: s_ready=%b busy=%b want 0 1", s_ready, busy);
    end
    rx_ready = 1'b1;
    wait_idle(60, ok);
    rx_ready = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL b2b_drain_timeout: busy=%b after 60 cycles want 0", busy);
    end
    vectors++;
    if ({n_wb - wb0, n_pcv - pcv0, pc_out} !== {32'd5, 32'd5, 16'hABCD}) begin
      miscompares++;
      $display("FAIL b2b_counts: wb=%0d pcv=%0d pc_out=%h want 5 5 abcd",
               n_wb - wb0, n_pcv - pcv0, pc_out);
    end
    for (int unsigned i = 0; i < 5; i++) begin
      want = 16'h1001 + 16'(i);
      vectors++;
      if (i >= br_log.size() || br_log[i] !== want) begin
        miscompares++;
        $display("FAIL b2b_order_%0d: got %h want %h", i,
                 (i < br_log.size()) ? br_log[i] : 16'hxxxx, want);
      end
    end
  endtask

  task automatic test_badop;
    int unsigned st0 = n_st, bad0 = n_bad, wf0 = n_wf, wb0 = n_wb, pcv0 = n_pcv;
    bit ok;
    rx_program_counter = 16'h0042;
    rx_ready = 1'b1;
    push(C_ST, 4'h0, 4'h0, 16'h0000);
    push(C_BAD, 4'h5, 4'h6, 16'hFFFF);
    push(C_ST, 4'h0, 4'h0, 16'h0000);
    wait_idle(40, ok);
    rx_ready = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL badop_timeout: busy=%b after 40 cycles want 0", busy);
    end
    vectors++;
    if ({n_st - st0, n_bad - bad0, n_wf - wf0, n_wb - wb0, n_pcv - pcv0} !==
        {32'd2, 32'd1, 32'd0, 32'd0, 32'd2}) begin
      miscompares++;
      $display("FAIL badop_pulses: st=%0d bad=%0d wf=%0d wb=%0d pcv=%0d want 2 1 0 0 2",
               n_st - st0, n_bad - bad0, n_wf - wf0, n_wb - wb0, n_pcv - pcv0);
    end
    vectors++;
    if ({tx_input_flags, tx_check_flags, tx_branch} !== {4'hA, 4'h3, 16'h1005}) begin
      miscompares++;
      $display("FAIL badop_payload_held: flags=%h check=%h branch=%h want a 3 1005",
               tx_input_flags, tx_check_flags, tx_branch);
    end
  endtask

  task automatic test_reset_mid;
    int unsigned st0, pcv0;
    rx_ready = 1'b0;
    push(C_ST, 4'h0, 4'h0, 16'h0000);
    push(C_ST, 4'h0, 4'h0, 16'h0000);
    push(C_ST, 4'h0, 4'h0, 16'h0000);
    vectors++;
    if ({busy, s_ready} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_mid_pre: busy=%b s_ready=%b want 1 1", busy, s_ready);
    end
    areset = 1'b1;
    enable = 1'b0;
    #1;
    vectors++;
    if ({tx_write_flags, tx_write_branch, tx_strobe, tx_input_flags, tx_check_flags, tx_branch,
         pc_out, pc_valid, busy, err_badop, err_timeout, tx_enable, s_ready} !== 48'd1) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: busy=%b s_ready=%b pc_out=%h tx_branch=%h flags=%h",
               busy, s_ready, pc_out, tx_branch, tx_input_flags);
    end
    @(negedge aclk);
    areset = 1'b0;
    enable = 1'b1;
    rx_ready = 1'b1;
    st0 = n_st;
    pcv0 = n_pcv;
    repeat (8) @(negedge aclk);
    rx_ready = 1'b0;
    vectors++;
    if ({n_st - st0, n_pcv - pcv0, busy} !== {32'd0, 32'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid_after: st=%0d pcv=%0d busy=%b want 0 0 0",
               n_st - st0, n_pcv - pcv0, busy);
    end
  endtask

  task automatic test_timeout;
`ifdef DECODER_DRIVER_TIMEOUT_EN
    int unsigned to0, pcv0;
    bit ok;
    rx_program_counter = 16'h7777;
    rx_ready = 1'b1;
    push(C_ST, 4'h0, 4'h0, 16'h0000);
    wait_idle(20, ok);
    rx_ready = 1'b0;
    rx_program_counter = 16'h9999;
    to0 = n_to;
    pcv0 = n_pcv;
    push(C_ST, 4'h0, 4'h0, 16'h0000);
    ok = 1'b0;
    for (int unsigned i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (n_to != to0) begin
        ok = 1'b1;
        break;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL timeout_fired: no err_timeout within 40 cycles");
    end
    vectors++;
    if (to_cyc - st_cyc !== 32'd11) begin
      miscompares++;
      $display("FAIL timeout_latency: %0d cycles strobe to err_timeout want 11", to_cyc - st_cyc);
    end
    @(negedge aclk);
    vectors++;
    if ({pc_out, n_pcv - pcv0, busy, n_to - to0} !== {16'h7777, 32'd0, 1'b0, 32'd1}) begin
      miscompares++;
      $display("FAIL timeout_after: pc_out=%h pcv=%0d busy=%b to=%0d want 7777 0 0 1",
               pc_out, n_pcv - pcv0, busy, n_to - to0);
    end
`else
    vectors++;
    if ({n_to, err_timeout} !== 33'd0) begin
      miscompares++;
      $display("FAIL timeout_tied: pulses=%0d err_timeout=%b want 0 0", n_to, err_timeout);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_set_flags;
    test_branch_step;
    test_back_to_back;
    test_badop;
    test_reset_mid;
    test_timeout;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
